dmem_access_unit: RTL and testbench

Memory-stage bus adapter between the pipeline datapath and data memory. It takes the MEM-stage ALU result (address), store data, size and read/write strobes. It runs a request/acknowledge transaction on a word-organised data-memory port with byte enables. It returns the load word right-aligned to byte lane 0 for the datapath's read-data extender. It holds the pipeline with `o_stall` while a transaction is in flight, flags misaligned accesses without touching memory, and aborts unacknowledged requests after a bounded wait.

---
 rtl/dmem_access_unit_if.sv | 32 +++
 rtl/dmem_access_unit.sv | 113 +++++++++++
 tb/tb_dmem_access_unit.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_unit_if.sv
// Signal bundle between the MEM-stage access unit, the pipeline datapath and data memory.
// The master modport is the access unit itself; the slave modport is its environment.
interface dmem_access_unit_if;
    logic        i_memRead;
    logic        i_memWrite;
    logic [1:0]  i_memSize;
    logic [31:0] i_addr;
    logic [31:0] i_writeData;
    logic        o_req;
    logic        o_we;
    logic [31:0] o_addr;
    logic [31:0] o_wdata;
    logic [3:0]  o_byteEn;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic [31:0] o_readData;
    logic        o_stall;
    logic        o_misaligned;
    logic        o_busFault;

    modport master (
        input  i_memRead, i_memWrite, i_memSize, i_addr, i_writeData, i_ack, i_rdata,
        output o_req, o_we, o_addr, o_wdata, o_byteEn, o_readData, o_stall, o_misaligned,
               o_busFault
    );

    modport slave (
        output i_memRead, i_memWrite, i_memSize, i_addr, i_writeData, i_ack, i_rdata,
        input  o_req, o_we, o_addr, o_wdata, o_byteEn, o_readData, o_stall, o_misaligned,
               o_busFault
    );
endinterface

// File: rtl/dmem_access_unit.sv
// MEM-stage adapter: turns load/store strobes into a req/ack word-memory transaction.
// state  | meaning
// IDLE   | waiting for an aligned access; misaligned ones are flagged only
// ACCESS | request held on the memory port until ack or timeout
// DONE   | stall released for one cycle so the pipeline advances
module dmem_access_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input logic                clk,
    input logic                reset_x,
    dmem_access_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state, state_nxt;
    logic [7:0]  wait_cnt;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  be_q;
    logic        we_q, fault_q;
    logic        access, misaligned, start, timed_out;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;

    assign access     = bus.i_memRead | bus.i_memWrite;
    assign misaligned = (bus.i_memSize == 2'b01 && bus.i_addr[0])
                     || (bus.i_memSize == 2'b10 && bus.i_addr[1:0] != 2'b00)
                     || (bus.i_memSize == 2'b11);
    assign start      = (state == IDLE) && access && !misaligned;
    // An ack in the final waiting cycle still wins over the abort.
    assign timed_out  = (state == ACCESS) && !bus.i_ack && (wait_cnt == TIMEOUT_CNT);

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCESS;
            ACCESS:  if (bus.i_ack || timed_out) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.o_req        = 1'b0;
        bus.o_we         = 1'b0;
        bus.o_stall      = 1'b0;
        bus.o_misaligned = (state == IDLE) && access && misaligned;
        case (state)
            IDLE:    bus.o_stall = start;
            ACCESS: begin
                bus.o_req   = 1'b1;
                bus.o_we    = we_q;
                bus.o_stall = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = bus.i_writeData;
        case (bus.i_memSize)
            2'b00: begin
                be_nxt    = 4'b0001 << bus.i_addr[1:0];
                wdata_nxt = {4{bus.i_writeData[7:0]}};
            end
            2'b01: begin
                be_nxt    = bus.i_addr[1] ? 4'b1100 : 4'b0011;
                wdata_nxt = {2{bus.i_writeData[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            we_q     <= 1'b0;
            wait_cnt <= '0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            fault_q <= timed_out;
            if (start) begin
                addr_q   <= bus.i_addr;
                wdata_q  <= wdata_nxt;
                be_q     <= be_nxt;
                we_q     <= bus.i_memWrite;
                wait_cnt <= '0;
            end else if (state == ACCESS && !bus.i_ack && !timed_out) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (state == ACCESS && bus.i_ack)
                rdata_q <= bus.i_rdata >> {addr_q[1:0], 3'b000};
            else if (timed_out)
                rdata_q <= '0;
        end
    end

    assign bus.o_addr     = {addr_q[31:2], 2'b00};
    assign bus.o_wdata    = wdata_q;
    assign bus.o_byteEn   = be_q;
    assign bus.o_readData = rdata_q;
    assign bus.o_busFault = fault_q;
endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with TIMEOUT=4 and a small ack-responder task.
module tb_dmem_access_unit;
    logic clk = 1'b0;
    logic reset_x;
    int   checks = 0;
    int   errors = 0;

    dmem_access_unit_if bus();

    dmem_access_unit #(.TIMEOUT(4)) dut (
        .clk     (clk),
        .reset_x (reset_x),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int          stall_n;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we, req_unstable, done_seen;

    task automatic drive(input logic rd, input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wd);
        bus.i_memRead   = rd;
        bus.i_memWrite  = wr;
        bus.i_memSize   = size;
        bus.i_addr      = addr;
        bus.i_writeData = wd;
    endtask

    // Answers the request after 'waits' extra cycles; returns at the DONE-cycle negedge.
    task automatic run_access(input int waits, input logic [31:0] rdata);
        int req_n;
        req_n        = 0;
        stall_n      = 0;
        req_unstable = 1'b0;
        done_seen    = 1'b0;
        bus.i_rdata  = rdata;
        for (int c = 0; c < 40 && !done_seen; c++) begin
            @(negedge clk);
            if (bus.o_stall) stall_n++;
            if (bus.o_req) begin
                if (req_n == 0) begin
                    cap_addr  = bus.o_addr;
                    cap_wdata = bus.o_wdata;
                    cap_be    = bus.o_byteEn;
                    cap_we    = bus.o_we;
                end else if (bus.o_addr !== cap_addr || bus.o_wdata !== cap_wdata ||
                             bus.o_byteEn !== cap_be || bus.o_we !== cap_we) begin
                    req_unstable = 1'b1;
                end
                req_n++;
                bus.i_ack = (req_n == waits + 1);
            end else if (req_n > 0) begin
                done_seen = 1'b1;
                bus.i_ack = 1'b0;
            end
        end
        bus.i_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset_x = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        bus.i_ack   = 1'b0;
        bus.i_rdata = 32'h0;
        #12;
        checks++; if (bus.o_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", bus.o_req); end
        checks++; if (bus.o_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", bus.o_we); end
        checks++; if (bus.o_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", bus.o_addr); end
        checks++; if (bus.o_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", bus.o_wdata); end
        checks++; if (bus.o_byteEn !== 4'h0) begin errors++; $display("FAIL reset_be got %b exp 0000", bus.o_byteEn); end
        checks++; if (bus.o_readData !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", bus.o_readData); end
        checks++; if (bus.o_busFault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", bus.o_busFault); end
        checks++; if (bus.o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall_idle got %b exp 0", bus.o_stall); end
        drive(1'b1, 1'b0, 2'b10, 32'h10, 32'h0);
        #1;
        checks++; if (bus.o_stall !== 1'b1) begin errors++; $display("FAIL reset_stall_comb got %b exp 1", bus.o_stall); end
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        reset_x = 1'b1;
    endtask

    task automatic test_word_load();
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 2'b10, 32'h0000_2004, 32'h0);
        run_access(0, 32'hDEADBEEF);
        checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL word_done got %b exp 1", done_seen); end
        checks++; if (stall_n != 2) begin errors++; $display("FAIL word_stall got %0d exp 2", stall_n); end
        checks++; if (cap_addr !== 32'h0000_2004) begin errors++; $display("FAIL word_addr got %h exp 00002004", cap_addr); end
        checks++; if (cap_be !== 4'b1111) begin errors++; $display("FAIL word_be got %b exp 1111", cap_be); end
        checks++; if (cap_we !== 1'b0) begin errors++; $display("FAIL word_we got %b exp 0", cap_we); end
        checks++; if (bus.o_readData !== 32'hDEADBEEF) begin errors++; $display("FAIL word_rdata got %h exp deadbeef", bus.o_readData); end
        checks++; if (bus.o_stall !== 1'b0) begin errors++; $display("FAIL word_done_stall got %b exp 0", bus.o_stall); end
        checks++; if (bus.o_busFault !== 1'b0) begin errors++; $display("FAIL word_fault got %b exp 0", bus.o_busFault); end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    endtask

    task automatic test_byte_store();
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 2'b00, 32'h0000_1003, 32'h0000_00A5);
        run_access(1, 32'hCAFEF00D);
        checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL bstore_done got %b exp 1", done_seen); end
        checks++; if (stall_n != 3) begin errors++; $display("FAIL bstore_stall got %0d exp 3", stall_n); end
        checks++; if (cap_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL bstore_wdata got %h exp a5a5a5a5", cap_wdata); end
        checks++; if (cap_be !== 4'b1000) begin errors++; $display("FAIL bstore_be got %b exp 1000", cap_be); end
        checks++; if (cap_addr !== 32'h0000_1000) begin errors++; $display("FAIL bstore_addr got %h exp 00001000", cap_addr); end
        checks++; if (cap_we !== 1'b1) begin errors++; $display("FAIL bstore_we got %b exp 1", cap_we); end
        checks++; if (bus.o_readData !== 32'h0000_00CA) begin errors++; $display("FAIL bstore_rdata got %h exp 000000ca", bus.o_readData); end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    endtask

    task automatic test_half_load_wait();
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 2'b01, 32'h0000_0102, 32'h0);
        run_access(3, 32'h1234_5678);
        checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL half_done got %b exp 1", done_seen); end
        checks++; if (stall_n != 5) begin errors++; $display("FAIL half_stall got %0d exp 5", stall_n); end
        checks++; if (req_unstable !== 1'b0) begin errors++; $display("FAIL half_req_stable got %b exp 0", req_unstable); end
        checks++; if (cap_be !== 4'b1100) begin errors++; $display("FAIL half_be got %b exp 1100", cap_be); end
        checks++; if (cap_addr !== 32'h0000_0100) begin errors++; $display("FAIL half_addr got %h exp 00000100", cap_addr); end
        checks++; if (bus.o_readData !== 32'h0000_1234) begin errors++; $display("FAIL half_rdata got %h exp 00001234", bus.o_readData); end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    endtask

    task automatic test_misaligned();
        logic [1:0]  sizes [3] = '{2'b10, 2'b11, 2'b01};
        logic [31:0] addrs [3] = '{32'h101, 32'h100, 32'h103};
        logic        wrs   [3] = '{1'b0, 1'b0, 1'b1};
        logic        mis_all, stall_any, req_any;
        for (int v = 0; v < 3; v++) begin
            @(posedge clk); #1;
            drive(!wrs[v], wrs[v], sizes[v], addrs[v], 32'h0000_5A5A);
            mis_all   = 1'b1;
            stall_any = 1'b0;
            req_any   = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (bus.o_misaligned !== 1'b1) mis_all = 1'b0;
                if (bus.o_stall !== 1'b0) stall_any = 1'b1;
                if (bus.o_req !== 1'b0) req_any = 1'b1;
            end
            checks++; if (mis_all !== 1'b1) begin errors++; $display("FAIL misal_flag[%0d] got %b exp 1", v, mis_all); end
            checks++; if (stall_any !== 1'b0) begin errors++; $display("FAIL misal_stall[%0d] got %b exp 0", v, stall_any); end
            checks++; if (req_any !== 1'b0) begin errors++; $display("FAIL misal_req[%0d] got %b exp 0", v, req_any); end
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        checks++; if (bus.o_misaligned !== 1'b0) begin errors++; $display("FAIL misal_clear got %b exp 0", bus.o_misaligned); end
    endtask

    task automatic test_timeout();
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 2'b10, 32'h0000_0400, 32'h0);
        run_access(1000, 32'h5555_5555);
        checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL tmo_done got %b exp 1", done_seen); end
        checks++; if (stall_n != 6) begin errors++; $display("FAIL tmo_stall got %0d exp 6", stall_n); end
        checks++; if (bus.o_busFault !== 1'b1) begin errors++; $display("FAIL tmo_fault got %b exp 1", bus.o_busFault); end
        checks++; if (bus.o_readData !== 32'h0) begin errors++; $display("FAIL tmo_rdata got %h exp 0", bus.o_readData); end
        checks++; if (bus.o_req !== 1'b0) begin errors++; $display("FAIL tmo_req got %b exp 0", bus.o_req); end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        bus.i_ack   = 1'b1;
        bus.i_rdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (bus.o_busFault !== 1'b0) begin errors++; $display("FAIL late_fault[%0d] got %b exp 0", c, bus.o_busFault); end
            checks++; if (bus.o_req !== 1'b0) begin errors++; $display("FAIL late_req[%0d] got %b exp 0", c, bus.o_req); end
            checks++; if (bus.o_readData !== 32'h0) begin errors++; $display("FAIL late_rdata[%0d] got %h exp 0", c, bus.o_readData); end
            checks++; if (bus.o_stall !== 1'b0) begin errors++; $display("FAIL late_stall[%0d] got %b exp 0", c, bus.o_stall); end
        end
        bus.i_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 2'b10, 32'h0000_0300, 32'h0);
        @(posedge clk); #1;
        checks++; if (bus.o_req !== 1'b1) begin errors++; $display("FAIL rstmid_pre_req got %b exp 1", bus.o_req); end
        #2 reset_x = 1'b0;
        #1;
        checks++; if (bus.o_req !== 1'b0) begin errors++; $display("FAIL rstmid_req got %b exp 0", bus.o_req); end
        checks++; if (bus.o_addr !== 32'h0) begin errors++; $display("FAIL rstmid_addr got %h exp 0", bus.o_addr); end
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        reset_x = 1'b1;
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 2'b10, 32'h0000_2008, 32'h0);
        run_access(1, 32'h1122_3344);
        checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL rstmid_done got %b exp 1", done_seen); end
        checks++; if (stall_n != 3) begin errors++; $display("FAIL rstmid_stall got %0d exp 3", stall_n); end
        checks++; if (cap_addr !== 32'h0000_2008) begin errors++; $display("FAIL rstmid_addr2 got %h exp 00002008", cap_addr); end
        checks++; if (bus.o_readData !== 32'h1122_3344) begin errors++; $display("FAIL rstmid_rdata got %h exp 11223344", bus.o_readData); end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 2'b00, 32'h0000_0041, 32'h0);
        run_access(0, 32'hA1B2_C3D4);
        checks++; if (stall_n != 2) begin errors++; $display("FAIL b2b_load_stall got %0d exp 2", stall_n); end
        checks++; if (cap_be !== 4'b0010) begin errors++; $display("FAIL b2b_load_be got %b exp 0010", cap_be); end
        checks++; if (bus.o_readData !== 32'h00A1_B2C3) begin errors++; $display("FAIL b2b_load_rdata got %h exp 00a1b2c3", bus.o_readData); end
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 2'b01, 32'h0000_0042, 32'h0000_BEEF);
        run_access(0, 32'h0);
        checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL b2b_store_done got %b exp 1", done_seen); end
        checks++; if (stall_n != 2) begin errors++; $display("FAIL b2b_store_stall got %0d exp 2", stall_n); end
        checks++; if (cap_wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL b2b_store_wdata got %h exp beefbeef", cap_wdata); end
        checks++; if (cap_be !== 4'b1100) begin errors++; $display("FAIL b2b_store_be got %b exp 1100", cap_be); end
        checks++; if (cap_addr !== 32'h0000_0040) begin errors++; $display("FAIL b2b_store_addr got %h exp 00000040", cap_addr); end
        checks++; if (cap_we !== 1'b1) begin errors++; $display("FAIL b2b_store_we got %b exp 1", cap_we); end
        checks++; if (bus.o_readData !== 32'h0) begin errors++; $display("FAIL b2b_store_rdata got %h exp 0", bus.o_readData); end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_store();
        test_half_load_wait();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
